// File: rtl/pipe_decode_ctrl.sv
// ID-stage decoder and ID/EX control register for an RV32I(+M) in-order pipeline.
// Generates load-use and multi-cycle MDU stalls, and bubbles the pipe on flush.
module pipe_decode_ctrl #(
    parameter int XLEN    = 32,
    parameter bit EN_MEXT = 1'b0,
    parameter int MDU_LAT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IR,
    input  logic        IR_VALID,
    input  logic        FLUSH,
    output logic        STALL,
    output logic        EX_REG_WRITE,
    output logic        EX_MEM_WRITE,
    output logic        EX_MEM_READ2,
    output logic        EX_BRANCH,
    output logic        EX_JUMP,
    output logic        EX_VALID,
    output logic        EX_ILLEGAL,
    output logic        EX_MDU_EN,
    output logic [1:0]  EX_RF_SEL,
    output logic [1:0]  EX_ALU_SRCB,
    output logic        EX_ALU_SRCA,
    output logic [3:0]  EX_ALU_FUN,
    output logic [2:0]  EX_FUNC3,
    output logic [2:0]  EX_MDU_OP,
    output logic [4:0]  EX_RD,
    output logic [4:0]  EX_RS1,
    output logic [4:0]  EX_RS2
);

    if (MDU_LAT < 1 || MDU_LAT > 15 || XLEN < 32) begin : g_bad_param
        $error("pipe_decode_ctrl: unsupported parameter value");
    end

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [3:0] MDU_RELOAD = 4'(MDU_LAT - 1);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read2;
        logic       branch;
        logic       jump;
        logic       illegal;
        logic       mdu_en;
        logic [1:0] rf_sel;
        logic [1:0] alu_srcb;
        logic       alu_srca;
        logic [3:0] alu_fun;
        logic [2:0] func3;
        logic [2:0] mdu_op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    ctrl_t      dec;
    logic       uses_rs1;
    logic       uses_rs2;
    ctrl_t      idex_p1;
    logic [3:0] mdu_cnt_p1;
    logic       mdu_busy;
    logic       load_use;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = IR[6:0];
    assign funct3 = IR[14:12];
    assign funct7 = IR[31:25];

    // ---- ID: combinational decode ----
    always_comb begin
        dec       = '0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        dec.valid = 1'b1;
        dec.func3 = funct3;
        dec.rd    = IR[11:7];
        dec.rs1   = IR[19:15];
        dec.rs2   = IR[24:20];
        unique case (opcode)
            OPC_LOAD: begin
                dec.alu_srcb  = 2'b01;
                dec.rf_sel    = 2'b00;
                dec.mem_read2 = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_srcb  = 2'b10;
                dec.mem_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_srcb  = 2'b01;
                dec.rf_sel    = 2'b01;
                dec.reg_write = 1'b1;
                dec.alu_fun   = {(funct3 == 3'b101) & IR[30], funct3};
                uses_rs1      = 1'b1;
            end
            OPC_OP: begin
                if (funct7 == 7'b0000001) begin
                    if (EN_MEXT) begin
                        dec.mdu_en    = 1'b1;
                        dec.mdu_op    = funct3;
                        dec.rf_sel    = 2'b01;
                        dec.reg_write = 1'b1;
                        uses_rs1      = 1'b1;
                        uses_rs2      = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end else begin
                    dec.rf_sel    = 2'b01;
                    dec.reg_write = 1'b1;
                    dec.alu_fun   = {IR[30], funct3};
                    uses_rs1      = 1'b1;
                    uses_rs2      = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.rf_sel    = 2'b11;
                dec.alu_srcb  = 2'b11;
                dec.alu_fun   = 4'b1001;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_srca  = 1'b1;
                dec.alu_srcb  = 2'b11;
                dec.rf_sel    = 2'b01;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.jump      = 1'b1;
                dec.rf_sel    = 2'b10;
                dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec.jump      = 1'b1;
                dec.rf_sel    = 2'b10;
                dec.reg_write = 1'b1;
                dec.alu_srcb  = 2'b01;
                uses_rs1      = 1'b1;
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.branch = 1'b1;
                    uses_rs1   = 1'b1;
                    uses_rs2   = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign mdu_busy = (mdu_cnt_p1 != 4'd0);
    assign load_use = IR_VALID && idex_p1.valid && idex_p1.mem_read2 && (idex_p1.rd != 5'd0) &&
                      ((uses_rs1 && (IR[19:15] == idex_p1.rd)) ||
                       (uses_rs2 && (IR[24:20] == idex_p1.rd)));
    assign STALL    = !FLUSH && (mdu_busy || load_use);

    // ---- ID/EX register and MDU occupancy counter ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idex_p1    <= '0;
            mdu_cnt_p1 <= 4'd0;
        end else if (FLUSH) begin
            idex_p1    <= '0;
            mdu_cnt_p1 <= 4'd0;
        end else if (mdu_busy) begin
            mdu_cnt_p1 <= mdu_cnt_p1 - 4'd1;
        end else if (load_use) begin
            idex_p1    <= '0;
        end else begin
            idex_p1    <= IR_VALID ? dec : '0;
            mdu_cnt_p1 <= (IR_VALID && dec.mdu_en) ? MDU_RELOAD : 4'd0;
        end
    end

    assign EX_VALID     = idex_p1.valid;
    assign EX_REG_WRITE = idex_p1.reg_write;
    assign EX_MEM_WRITE = idex_p1.mem_write;
    assign EX_MEM_READ2 = idex_p1.mem_read2;
    assign EX_BRANCH    = idex_p1.branch;
    assign EX_JUMP      = idex_p1.jump;
    assign EX_ILLEGAL   = idex_p1.illegal;
    assign EX_MDU_EN    = idex_p1.mdu_en;
    assign EX_RF_SEL    = idex_p1.rf_sel;
    assign EX_ALU_SRCB  = idex_p1.alu_srcb;
    assign EX_ALU_SRCA  = idex_p1.alu_srca;
    assign EX_ALU_FUN   = idex_p1.alu_fun;
    assign EX_FUNC3     = idex_p1.func3;
    assign EX_MDU_OP    = idex_p1.mdu_op;
    assign EX_RD        = idex_p1.rd;
    assign EX_RS1       = idex_p1.rs1;
    assign EX_RS2       = idex_p1.rs2;

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Directed bench for pipe_decode_ctrl: decode table, load-use, MDU stall, flush and async reset.
module tb_pipe_decode_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IR;
    logic        IR_VALID;
    logic        FLUSH;

    logic       m_stall, m_rw, m_mw, m_mr, m_br, m_jp, m_v, m_il, m_mdu, m_srca;
    logic [1:0] m_rf, m_srcb;
    logic [3:0] m_fun;
    logic [2:0] m_f3, m_mop;
    logic [4:0] m_rd, m_rs1, m_rs2;

    logic       n_stall, n_rw, n_mw, n_mr, n_br, n_jp, n_v, n_il, n_mdu, n_srca;
    logic [1:0] n_rf, n_srcb;
    logic [3:0] n_fun;
    logic [2:0] n_f3, n_mop;
    logic [4:0] n_rd, n_rs1, n_rs2;

    pipe_decode_ctrl #(.XLEN(32), .EN_MEXT(1'b1), .MDU_LAT(4)) dut_m (
        .CLK(CLK), .RST_N(RST_N), .IR(IR), .IR_VALID(IR_VALID), .FLUSH(FLUSH),
        .STALL(m_stall), .EX_REG_WRITE(m_rw), .EX_MEM_WRITE(m_mw), .EX_MEM_READ2(m_mr),
        .EX_BRANCH(m_br), .EX_JUMP(m_jp), .EX_VALID(m_v), .EX_ILLEGAL(m_il), .EX_MDU_EN(m_mdu),
        .EX_RF_SEL(m_rf), .EX_ALU_SRCB(m_srcb), .EX_ALU_SRCA(m_srca), .EX_ALU_FUN(m_fun),
        .EX_FUNC3(m_f3), .EX_MDU_OP(m_mop), .EX_RD(m_rd), .EX_RS1(m_rs1), .EX_RS2(m_rs2)
    );

    pipe_decode_ctrl #(.XLEN(32), .EN_MEXT(1'b0), .MDU_LAT(4)) dut_n (
        .CLK(CLK), .RST_N(RST_N), .IR(IR), .IR_VALID(IR_VALID), .FLUSH(FLUSH),
        .STALL(n_stall), .EX_REG_WRITE(n_rw), .EX_MEM_WRITE(n_mw), .EX_MEM_READ2(n_mr),
        .EX_BRANCH(n_br), .EX_JUMP(n_jp), .EX_VALID(n_v), .EX_ILLEGAL(n_il), .EX_MDU_EN(n_mdu),
        .EX_RF_SEL(n_rf), .EX_ALU_SRCB(n_srcb), .EX_ALU_SRCA(n_srca), .EX_ALU_FUN(n_fun),
        .EX_FUNC3(n_f3), .EX_MDU_OP(n_mop), .EX_RD(n_rd), .EX_RS1(n_rs1), .EX_RS2(n_rs2)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       v, rw, mw, mr, br, jp, il, mdu;
        logic [1:0] rf, srcb;
        logic       srca;
        logic [3:0] fun;
        logic [2:0] f3, mop;
        logic [4:0] rd, rs1, rs2;
    } ex_t;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        iv;
        ex_t         exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic ex_t mk(input logic v, rw, mw, mr, br, jp, il, mdu,
                               input logic [1:0] rf, srcb, input logic srca,
                               input logic [3:0] fun, input logic [2:0] f3, mop,
                               input logic [4:0] rd, rs1, rs2);
        ex_t e;
        e = {v, rw, mw, mr, br, jp, il, mdu, rf, srcb, srca, fun, f3, mop, rd, rs1, rs2};
        return e;
    endfunction

    function automatic ex_t ex_m();
        return {m_v, m_rw, m_mw, m_mr, m_br, m_jp, m_il, m_mdu, m_rf, m_srcb, m_srca,
                m_fun, m_f3, m_mop, m_rd, m_rs1, m_rs2};
    endfunction

    function automatic ex_t ex_n();
        return {n_v, n_rw, n_mw, n_mr, n_br, n_jp, n_il, n_mdu, n_rf, n_srcb, n_srca,
                n_fun, n_f3, n_mop, n_rd, n_rs1, n_rs2};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    localparam logic [31:0] I_ADDI_X1   = 32'h00500093;
    localparam logic [31:0] I_LW_X5     = 32'h00012283;
    localparam logic [31:0] I_ADD_X5USE = 32'h00728333;
    localparam logic [31:0] I_ADDI_X7   = 32'h00538313;
    localparam logic [31:0] I_LUI_RS1_5 = 32'h00028337;
    localparam logic [31:0] I_LW_X0     = 32'h00012003;
    localparam logic [31:0] I_ADD_X0USE = 32'h00700333;
    localparam logic [31:0] I_MUL       = 32'h022081B3;

    vec_t vecs[15];
    int   nstall;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"addi",     32'h00500093, 1'b1, mk(1,1,0,0,0,0,0,0, 2'b01,2'b01,0, 4'b0000,3'b000,3'b0, 5'd1, 5'd0, 5'd5)};
        vecs[1]  = '{"srai",     32'h4041D113, 1'b1, mk(1,1,0,0,0,0,0,0, 2'b01,2'b01,0, 4'b1101,3'b101,3'b0, 5'd2, 5'd3, 5'd4)};
        vecs[2]  = '{"addi_b30", 32'h40028213, 1'b1, mk(1,1,0,0,0,0,0,0, 2'b01,2'b01,0, 4'b0000,3'b000,3'b0, 5'd4, 5'd5, 5'd0)};
        vecs[3]  = '{"sub",      32'h40A48433, 1'b1, mk(1,1,0,0,0,0,0,0, 2'b01,2'b00,0, 4'b1000,3'b000,3'b0, 5'd8, 5'd9, 5'd10)};
        vecs[4]  = '{"sw",       32'h00B62423, 1'b1, mk(1,0,1,0,0,0,0,0, 2'b00,2'b10,0, 4'b0000,3'b010,3'b0, 5'd8, 5'd12,5'd11)};
        vecs[5]  = '{"lui",      32'h000016B7, 1'b1, mk(1,1,0,0,0,0,0,0, 2'b11,2'b11,0, 4'b1001,3'b001,3'b0, 5'd13,5'd0, 5'd0)};
        vecs[6]  = '{"auipc",    32'h00000717, 1'b1, mk(1,1,0,0,0,0,0,0, 2'b01,2'b11,1, 4'b0000,3'b000,3'b0, 5'd14,5'd0, 5'd0)};
        vecs[7]  = '{"jal",      32'h000000EF, 1'b1, mk(1,1,0,0,0,1,0,0, 2'b10,2'b00,0, 4'b0000,3'b000,3'b0, 5'd1, 5'd0, 5'd0)};
        vecs[8]  = '{"jalr",     32'h000780E7, 1'b1, mk(1,1,0,0,0,1,0,0, 2'b10,2'b01,0, 4'b0000,3'b000,3'b0, 5'd1, 5'd15,5'd0)};
        vecs[9]  = '{"beq",      32'h01180063, 1'b1, mk(1,0,0,0,1,0,0,0, 2'b00,2'b00,0, 4'b0000,3'b000,3'b0, 5'd0, 5'd16,5'd17)};
        vecs[10] = '{"bltu",     32'h01186063, 1'b1, mk(1,0,0,0,1,0,0,0, 2'b00,2'b00,0, 4'b0000,3'b110,3'b0, 5'd0, 5'd16,5'd17)};
        vecs[11] = '{"br_f3_010",32'h01182063, 1'b1, mk(1,0,0,0,0,0,1,0, 2'b00,2'b00,0, 4'b0000,3'b010,3'b0, 5'd0, 5'd16,5'd17)};
        vecs[12] = '{"bad_opc",  32'h0000007F, 1'b1, mk(1,0,0,0,0,0,1,0, 2'b00,2'b00,0, 4'b0000,3'b000,3'b0, 5'd0, 5'd0, 5'd0)};
        vecs[13] = '{"iv0",      32'h00500093, 1'b0, ex_t'(0)};
        vecs[14] = '{"lw",       32'h00012283, 1'b1, mk(1,1,0,1,0,0,0,0, 2'b00,2'b01,0, 4'b0000,3'b010,3'b0, 5'd5, 5'd2, 5'd0)};

        RST_N = 1'b0; IR = 32'h0; IR_VALID = 1'b0; FLUSH = 1'b0;
        #2;
        chk("reset_ex", 64'(ex_m()), 64'(ex_t'(0)));
        chk("reset_stall", 64'(m_stall), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            IR = vecs[i].ir;
            IR_VALID = vecs[i].iv;
            tick();
            chk(vecs[i].name, 64'(ex_m()), 64'(vecs[i].exp));
        end

        // Load-use: unread rs fields must not stall; a real use stalls once.
        IR = I_LW_X5; IR_VALID = 1'b1;
        tick();
        IR = I_ADDI_X7; #1;
        chk("opimm_rs2_ignored", 64'(m_stall), 64'd0);
        IR = I_LUI_RS1_5; #1;
        chk("lui_rs1_ignored", 64'(m_stall), 64'd0);
        IR = I_ADD_X5USE; #1;
        chk("loaduse_stall", 64'(m_stall), 64'd1);
        tick();
        chk("loaduse_bubble", 64'(ex_m()), 64'(ex_t'(0)));
        chk("loaduse_stall_once", 64'(m_stall), 64'd0);
        tick();
        chk("loaduse_add", 64'(ex_m()),
            64'(mk(1,1,0,0,0,0,0,0, 2'b01,2'b00,0, 4'b0000,3'b000,3'b0, 5'd6,5'd5,5'd7)));

        IR = I_LW_X0;
        tick();
        IR = I_ADD_X0USE; #1;
        chk("lw_x0_no_stall", 64'(m_stall), 64'd0);

        // MUL: three busy cycles on the M-enabled core, illegal on the other.
        IR = I_MUL;
        tick();
        chk("mul_ex", 64'(ex_m()),
            64'(mk(1,1,0,0,0,0,0,1, 2'b01,2'b00,0, 4'b0000,3'b000,3'b000, 5'd3,5'd1,5'd2)));
        chk("mul_illegal_noM", 64'(ex_n()),
            64'(mk(1,0,0,0,0,0,1,0, 2'b00,2'b00,0, 4'b0000,3'b000,3'b000, 5'd3,5'd1,5'd2)));
        IR = I_ADDI_X1; #1;
        nstall = 0;
        while (m_stall === 1'b1 && nstall < 20) begin
            nstall++;
            chk("mul_mdu_en_held", 64'(m_mdu), 64'd1);
            tick();
        end
        chk("mul_stall_cycles", 64'(nstall), 64'd3);
        tick();
        chk("after_mul_addi", 64'(ex_m()), 64'(vecs[0].exp));

        // Flush in the second busy cycle.
        IR = I_MUL;
        tick();
        IR = I_ADDI_X1;
        tick();
        chk("busy2_stall", 64'(m_stall), 64'd1);
        FLUSH = 1'b1; #1;
        chk("flush_forces_nostall", 64'(m_stall), 64'd0);
        tick();
        FLUSH = 1'b0; #1;
        chk("flush_bubble_valid", 64'(m_v), 64'd0);
        chk("flush_mdu_en", 64'(m_mdu), 64'd0);
        chk("flush_cnt_clear_stall", 64'(m_stall), 64'd0);
        tick();
        chk("post_flush_addi", 64'(ex_m()), 64'(vecs[0].exp));

        // Asynchronous reset between edges during a load-use stall.
        IR = I_LW_X5;
        tick();
        IR = I_ADD_X5USE; #1;
        chk("pre_reset_stall", 64'(m_stall), 64'd1);
        #2;
        RST_N = 1'b0; #1;
        chk("async_reset_ex", 64'(ex_m()), 64'(ex_t'(0)));
        chk("async_reset_stall", 64'(m_stall), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk("first_edge_decode", 64'(ex_m()),
            64'(mk(1,1,0,0,0,0,0,0, 2'b01,2'b00,0, 4'b0000,3'b000,3'b0, 5'd6,5'd5,5'd7)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
